// File: rtl/entropy_health.sv
// Online health monitor for a raw single-bit noise stream.
// Forwards the raw bit through one register stage and runs the
// repetition-count test (RCT) and adaptive-proportion test (APT) in
// parallel, reporting failures as pulses, a sticky alarm and a
// saturating failure counter.
module entropy_health #(
    parameter int unsigned RCT_C = 31,
    parameter int unsigned APT_W = 1024,
    parameter int unsigned APT_C = 589
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw,
    input  logic        clear,
    output logic        data,
    output logic        rct_fail,
    output logic        apt_fail,
    output logic        alarm,
    output logic [15:0] fail_cnt
);

    localparam logic [15:0] RCT_CUT  = 16'(RCT_C);
    localparam logic [15:0] APT_CUT  = 16'(APT_C);
    localparam logic [15:0] APT_LAST = 16'(APT_W - 1);

    // data_q doubles as the "previous sample" for the RCT; first_q marks
    // that no previous sample exists yet since reset.
    logic        data_q;
    logic        first_q;
    logic [15:0] rct_cnt_q, rct_cnt_d;
    logic        rct_fail_q, rct_fail_d;
    logic        rct_restart;

    logic [15:0] pos_q, pos_d;
    logic        ref_q, ref_d;
    logic [15:0] apt_cnt_q, apt_cnt_d;
    logic        fired_q, fired_d;
    logic        apt_fail_q, apt_fail_d;
    logic        win_start;
    logic        apt_match;

    logic        alarm_q, alarm_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;
    logic [16:0] fail_sum;
    logic        any_fail;

    // Repetition count: restart on a bit change, saturate at the cutoff,
    // and pulse only on the transition into the cutoff.
    always_comb begin
        rct_restart = first_q || (raw != data_q);
        if (rct_restart) begin
            rct_cnt_d = 16'd1;
        end else if (rct_cnt_q == RCT_CUT) begin
            rct_cnt_d = RCT_CUT;
        end else begin
            rct_cnt_d = rct_cnt_q + 16'd1;
        end
        rct_fail_d = !rct_restart && (rct_cnt_q != RCT_CUT) && (rct_cnt_d == RCT_CUT);
    end

    // Adaptive proportion: a window opens whenever the position counter is
    // zero (including right after reset); the first bit becomes the reference.
    always_comb begin
        win_start = (pos_q == 16'd0);
        apt_match = (raw == ref_q);
        pos_d     = (pos_q == APT_LAST) ? 16'd0 : pos_q + 16'd1;
        if (win_start) begin
            ref_d      = raw;
            apt_cnt_d  = 16'd1;
            fired_d    = 1'b0;
            apt_fail_d = 1'b0;
        end else begin
            ref_d      = ref_q;
            apt_cnt_d  = apt_cnt_q + {15'd0, apt_match};
            apt_fail_d = !fired_q && apt_match && (apt_cnt_d == APT_CUT);
            fired_d    = fired_q || apt_fail_d;
        end
    end

    // Alarm and failure counter react to the registered pulses; a pulse
    // overrides a simultaneous clear.
    always_comb begin
        any_fail = rct_fail_q || apt_fail_q;
        if (any_fail) begin
            alarm_d = 1'b1;
        end else if (clear) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
        fail_sum   = {1'b0, fail_cnt_q} + {16'd0, rct_fail_q} + {16'd0, apt_fail_q};
        fail_cnt_d = fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
    end

    // State registers with synchronous reset to the "no previous sample" state.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= 1'b0;
            first_q    <= 1'b1;
            rct_cnt_q  <= 16'd0;
            rct_fail_q <= 1'b0;
            pos_q      <= 16'd0;
            ref_q      <= 1'b0;
            apt_cnt_q  <= 16'd0;
            fired_q    <= 1'b0;
            apt_fail_q <= 1'b0;
            alarm_q    <= 1'b0;
            fail_cnt_q <= 16'd0;
        end else begin
            data_q     <= raw;
            first_q    <= 1'b0;
            rct_cnt_q  <= rct_cnt_d;
            rct_fail_q <= rct_fail_d;
            pos_q      <= pos_d;
            ref_q      <= ref_d;
            apt_cnt_q  <= apt_cnt_d;
            fired_q    <= fired_d;
            apt_fail_q <= apt_fail_d;
            alarm_q    <= alarm_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign data     = data_q;
    assign rct_fail = rct_fail_q;
    assign apt_fail = apt_fail_q;
    assign alarm    = alarm_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_entropy_health.sv
// Bench for entropy_health: two instances (APT cutoff 12 and 4) share the
// stimulus; a history-based reference model checks every sample, with a
// vector table and hand-written sequences for the corner cases.
module tb_entropy_health;

    localparam int RCT_C  = 4;
    localparam int APT_W  = 16;
    localparam int APT_C  = 12;
    localparam int APT_C2 = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        raw   = 1'b0;
    logic        clear = 1'b0;
    logic        data, rct_fail, apt_fail, alarm;
    logic [15:0] fail_cnt;
    logic        data2, rct_fail2, apt_fail2, alarm2;
    logic [15:0] fail_cnt2;

    entropy_health #(.RCT_C(RCT_C), .APT_W(APT_W), .APT_C(APT_C)) dut (
        .clk(clk), .reset(reset), .raw(raw), .clear(clear),
        .data(data), .rct_fail(rct_fail), .apt_fail(apt_fail),
        .alarm(alarm), .fail_cnt(fail_cnt)
    );

    entropy_health #(.RCT_C(RCT_C), .APT_W(APT_W), .APT_C(APT_C2)) dut2 (
        .clk(clk), .reset(reset), .raw(raw), .clear(clear),
        .data(data2), .rct_fail(rct_fail2), .apt_fail(apt_fail2),
        .alarm(alarm2), .fail_cnt(fail_cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: full sample history since reset, plus the
    // alarm/counter state and last pulses of each instance.
    bit hist[$];
    int m_alarm[2];
    int m_cnt[2];
    int m_prct[2];
    int m_papt[2];
    int cuts[2];

    typedef struct {
        bit raw;
        bit clr;
        bit rct;
        bit apt;
        bit alm;
        int cnt;
    } vec_t;
    vec_t tbl[11];

    int apt_hits, apt_at, rct_hits;
    bit b, c;
    int len, stick;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Length of the run of identical bits ending at the newest sample,
    // counted no further than one beyond the cutoff.
    function automatic int run_len();
        int n = hist.size() - 1;
        int l = 0;
        for (int j = n; j >= 0 && l <= RCT_C; j--) begin
            if (hist[j] == hist[n]) l++;
            else break;
        end
        return l;
    endfunction

    // APT fires on the sample where the number of window samples equal to
    // the window's first sample becomes exactly the cutoff.
    function automatic bit apt_fire(input int cut);
        int n = hist.size() - 1;
        int w = n - (n % APT_W);
        int cnt = 0;
        if (n == w || hist[n] != hist[w]) return 1'b0;
        for (int j = w; j <= n; j++) begin
            if (hist[j] == hist[w]) cnt++;
        end
        return (cnt == cut);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        raw   = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_data", data, 0);
        chk("rst_rct", rct_fail, 0);
        chk("rst_apt", apt_fail, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_cnt", fail_cnt, 0);
        chk("rst_alarm2", alarm2, 0);
        chk("rst_cnt2", fail_cnt2, 0);
        hist.delete();
        for (int d = 0; d < 2; d++) begin
            m_alarm[d] = 0;
            m_cnt[d]   = 0;
            m_prct[d]  = 0;
            m_papt[d]  = 0;
        end
        reset = 1'b0;
        $display("reset");
    endtask

    // One sample: drive, wait past the edge, advance the model, compare.
    task automatic step(input bit r, input bit cl);
        int e_rct;
        int e_apt[2];
        raw   = r;
        clear = cl;
        @(posedge clk);
        #1;
        hist.push_back(r);
        e_rct = (run_len() == RCT_C) ? 1 : 0;
        for (int d = 0; d < 2; d++) begin
            e_apt[d] = apt_fire(cuts[d]) ? 1 : 0;
            if (m_prct[d] != 0 || m_papt[d] != 0) m_alarm[d] = 1;
            else if (cl) m_alarm[d] = 0;
            m_cnt[d] = m_cnt[d] + m_prct[d] + m_papt[d];
            if (m_cnt[d] > 65535) m_cnt[d] = 65535;
            m_prct[d] = e_rct;
            m_papt[d] = e_apt[d];
        end
        chk("data", data, r);
        chk("rct_fail", rct_fail, e_rct);
        chk("apt_fail", apt_fail, e_apt[0]);
        chk("alarm", alarm, m_alarm[0]);
        chk("fail_cnt", fail_cnt, m_cnt[0]);
        chk("data2", data2, r);
        chk("rct_fail2", rct_fail2, e_rct);
        chk("apt_fail2", apt_fail2, e_apt[1]);
        chk("alarm2", alarm2, m_alarm[1]);
        chk("fail_cnt2", fail_cnt2, m_cnt[1]);
        $display("sample n=%0d raw=%0b clr=%0b data=%0b rct=%0b apt=%0b alarm=%0b cnt=%0d apt2=%0b cnt2=%0d",
                 hist.size() - 1, r, cl, data, rct_fail, apt_fail, alarm, fail_cnt, apt_fail2, fail_cnt2);
    endtask

    initial begin
        cuts[0] = APT_C;
        cuts[1] = APT_C2;
        // Run of six ones then four zeros (and one more zero to see the count).
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};

        // Alternating pattern: no failures on the cutoff-12 instance.
        do_reset();
        rct_hits = 0;
        apt_hits = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'(i % 2), 1'b0);
            rct_hits += int'(rct_fail);
            apt_hits += int'(apt_fail);
        end
        chk("alt_rct_hits", rct_hits, 0);
        chk("alt_apt_hits", apt_hits, 0);
        chk("alt_alarm", alarm, 0);
        chk("alt_cnt", fail_cnt, 0);

        // Vector table: RCT runs, plus both tests failing together on dut2.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].raw, tbl[i].clr);
            chk("tbl_rct", rct_fail, tbl[i].rct);
            chk("tbl_apt", apt_fail, tbl[i].apt);
            chk("tbl_alarm", alarm, tbl[i].alm);
            chk("tbl_cnt", fail_cnt, tbl[i].cnt);
            if (i == 3) begin
                chk("both_rct2", rct_fail2, 1);
                chk("both_apt2", apt_fail2, 1);
            end
            if (i == 4) chk("both_cnt2", fail_cnt2, 2);
        end

        // APT window: 12 zeros with runs of at most 3, then an alternating window.
        do_reset();
        apt_hits = 0;
        apt_at   = -1;
        rct_hits = 0;
        for (int i = 0; i < 16; i++) begin
            step(((i % 4) == 3) ? 1'b1 : 1'b0, 1'b0);
            if (apt_fail) begin
                apt_hits++;
                apt_at = i;
            end
            rct_hits += int'(rct_fail);
        end
        chk("win_apt_hits", apt_hits, 1);
        chk("win_apt_at", apt_at, 14);
        chk("win_rct_hits", rct_hits, 0);
        apt_hits = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'(i % 2), 1'b0);
            apt_hits += int'(apt_fail);
        end
        chk("win2_apt_hits", apt_hits, 0);

        // Constant zeros with clear in the pulse cycle and again later.
        do_reset();
        apt_hits = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i == 4 || i == 7) ? 1'b1 : 1'b0);
            apt_hits += int'(apt_fail);
            if (i == 3) chk("clr_rct_at3", rct_fail, 1);
            if (i == 4) chk("clr_alarm_held", alarm, 1);
            if (i == 7) begin
                chk("clr_alarm_drop", alarm, 0);
                chk("clr_cnt_kept", fail_cnt, 1);
            end
        end
        chk("clr_apt_hits", apt_hits, 0);

        // Reset at window position 10 with a run of three, then resume.
        do_reset();
        for (int i = 0; i < 10; i++) step((i < 7) ? 1'(i % 2) : 1'b1, 1'b0);
        do_reset();
        step(1'b1, 1'b0);
        chk("mid_rct", rct_fail, 0);
        chk("mid_apt", apt_fail, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("mid_rct_restart", rct_fail, 1);
        chk("mid_apt2_restart", apt_fail2, 1);

        // Randomized segments with sticky bits to provoke runs and windows.
        for (int s = 0; s < 10; s++) begin
            do_reset();
            len   = $urandom_range(200, 60);
            stick = $urandom_range(95, 40);
            b     = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(99, 0) >= stick) b = ~b;
                c = ($urandom_range(99, 0) < 4);
                step(b, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
